// File: rtl/plot_arbiter.sv
// Arbitrates clear/player/cpu requests onto a single VGA pixel-write port.
// Define PLOT_ARB_RR_EN for player/cpu round robin; otherwise player > cpu.
module plot_arbiter #(
  parameter int          SPRITE_W     = 4,
  parameter int          SPRITE_H     = 4,
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr_req,
  input  logic       p_req,
  input  logic       c_req,
  input  logic [7:0] p_x,
  input  logic [7:0] c_x,
  input  logic [6:0] p_y,
  input  logic [6:0] c_y,
  input  logic [2:0] p_colour,
  input  logic [2:0] c_colour,
  output logic       clr_ack,
  output logic       p_ack,
  output logic       c_ack,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for a request, grant decided combinationally
  // DRAW  | one sprite pixel per cycle from latched origin
  // CLEAR | one screen pixel per cycle in CLEAR_COLOUR
  // DONE  | single cycle, ack pulse to the granted requester
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRAW  = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] WHO_CLR = 2'd0;
  localparam logic [1:0] WHO_P   = 2'd1;
  localparam logic [1:0] WHO_C   = 2'd2;

  localparam logic [7:0] SPR_WM1 = 8'(SPRITE_W - 1);
  localparam logic [6:0] SPR_HM1 = 7'(SPRITE_H - 1);
  localparam logic [7:0] SCR_WM1 = 8'(SCREEN_W - 1);
  localparam logic [6:0] SCR_HM1 = 7'(SCREEN_H - 1);
  localparam logic [8:0] SCR_W9  = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H8  = 8'(SCREEN_H);

  logic [1:0] state;
  logic [1:0] who;
  logic [7:0] cx, base_x, lim_x, nx, src_x, off_x, win_x;
  logic [6:0] cy, base_y, lim_y, ny, src_y, off_y, win_y;
  logic [2:0] win_colour;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       gnt_clr, gnt_p, gnt_c, last_px, vis;

`ifdef PLOT_ARB_RR_EN
  logic last_p;

  always_comb begin
    gnt_clr = clr_req;
    gnt_p   = !clr_req && p_req && (!c_req || !last_p);
    gnt_c   = !clr_req && c_req && (!p_req || last_p);
  end
`else
  always_comb begin
    gnt_clr = clr_req;
    gnt_p   = !clr_req && p_req;
    gnt_c   = !clr_req && !p_req && c_req;
  end
`endif

  always_comb begin
    win_x      = gnt_clr ? 8'd0 : (gnt_p ? p_x : c_x);
    win_y      = gnt_clr ? 7'd0 : (gnt_p ? p_y : c_y);
    win_colour = gnt_clr ? CLEAR_COLOUR : (gnt_p ? p_colour : c_colour);
    lim_x      = (state == CLEAR) ? SCR_WM1 : SPR_WM1;
    lim_y      = (state == CLEAR) ? SCR_HM1 : SPR_HM1;
    last_px    = (cx == lim_x) && (cy == lim_y);
    nx         = (cx == lim_x) ? 8'd0 : cx + 8'd1;
    ny         = (cx == lim_x) ? cy + 7'd1 : cy;
    // In IDLE the first pixel is formed straight from the winner's inputs.
    src_x      = (state == IDLE) ? win_x : base_x;
    src_y      = (state == IDLE) ? win_y : base_y;
    off_x      = (state == IDLE) ? 8'd0 : nx;
    off_y      = (state == IDLE) ? 7'd0 : ny;
    sum_x      = {1'b0, src_x} + {1'b0, off_x};
    sum_y      = {1'b0, src_y} + {1'b0, off_y};
    vis        = !sum_x[8] && !sum_y[7] && (sum_x < SCR_W9) && (sum_y < SCR_H8);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state   <= IDLE;
      who     <= WHO_CLR;
      cx      <= '0;
      cy      <= '0;
      base_x  <= '0;
      base_y  <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      clr_ack <= 1'b0;
      p_ack   <= 1'b0;
      c_ack   <= 1'b0;
`ifdef PLOT_ARB_RR_EN
      last_p  <= 1'b0;
`endif
    end else begin
      clr_ack <= 1'b0;
      p_ack   <= 1'b0;
      c_ack   <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_clr || gnt_p || gnt_c) begin
            state  <= gnt_clr ? CLEAR : DRAW;
            who    <= gnt_clr ? WHO_CLR : (gnt_p ? WHO_P : WHO_C);
            base_x <= win_x;
            base_y <= win_y;
            cx     <= '0;
            cy     <= '0;
            x      <= sum_x[7:0];
            y      <= sum_y[6:0];
            colour <= win_colour;
            plot   <= vis;
`ifdef PLOT_ARB_RR_EN
            if (gnt_p || gnt_c) last_p <= gnt_p;
`endif
          end
        end
        DRAW, CLEAR: begin
          if (last_px) begin
            state   <= DONE;
            plot    <= 1'b0;
            clr_ack <= (who == WHO_CLR);
            p_ack   <= (who == WHO_P);
            c_ack   <= (who == WHO_C);
          end else begin
            cx   <= nx;
            cy   <= ny;
            x    <= sum_x[7:0];
            y    <= sum_y[6:0];
            plot <= vis;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter (default 4x4 sprite, 160x120 screen).
module tb_plot_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       clr_req = 1'b0, p_req = 1'b0, c_req = 1'b0;
  logic [7:0] p_x = '0, c_x = '0;
  logic [6:0] p_y = '0, c_y = '0;
  logic [2:0] p_colour = '0, c_colour = '0;
  logic       clr_ack, p_ack, c_ack, plot, busy;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int errors = 0;
  int checks = 0;

  plot_arbiter dut (
    .clk(clk), .resetn(resetn),
    .clr_req(clr_req), .p_req(p_req), .c_req(c_req),
    .p_x(p_x), .c_x(c_x), .p_y(p_y), .c_y(c_y),
    .p_colour(p_colour), .c_colour(c_colour),
    .clr_ack(clr_ack), .p_ack(p_ack), .c_ack(c_ack),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, plot, clr_ack, p_ack, c_ack} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=00000", {busy, plot, clr_ack, p_ack, c_ack});
    end
    checks++;
    if ({x, y, colour} !== 18'd0) begin
      errors++;
      $display("FAIL reset_xyc got=%0d,%0d,%0d want=0,0,0", x, y, colour);
    end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_player_draw();
    logic [7:0] ex;
    logic [6:0] ey;
    p_x = 8'd10; p_y = 7'd20; p_colour = 3'b100; p_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ex = 8'(10 + i % 4);
      ey = 7'(20 + i / 4);
      checks++;
      if (x !== ex || y !== ey || plot !== 1'b1 || colour !== 3'b100 || busy !== 1'b1) begin
        errors++;
        $display("FAIL draw_px%0d got=(%0d,%0d,c%0d,p%b) want=(%0d,%0d,c4,p1)", i, x, y, colour, plot, ex, ey);
      end
      // Moving the inputs mid-draw must not disturb the latched sprite.
      if (i == 0) begin
        p_x = 8'd99; p_y = 7'd5; p_colour = 3'b001;
      end
    end
    @(negedge clk);
    checks++;
    if ({p_ack, c_ack, clr_ack, plot, busy} !== 5'b10001) begin
      errors++;
      $display("FAIL draw_done got=%b want=10001", {p_ack, c_ack, clr_ack, plot, busy});
    end
    p_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || p_ack !== 1'b0 || x !== 8'd13 || y !== 7'd23 || colour !== 3'b100) begin
      errors++;
      $display("FAIL draw_idle_hold got=b%b a%b (%0d,%0d,c%0d) want=b0 a0 (13,23,c4)", busy, p_ack, x, y, colour);
    end
  endtask

  task automatic test_clip();
    logic [7:0] ex;
    logic       ep;
    int         nplot = 0;
    p_x = 8'd158; p_y = 7'd118; p_colour = 3'b101; p_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ex = 8'(158 + i % 4);
      ep = (i % 4 < 2) && (i / 4 < 2);
      if (plot === 1'b1) nplot++;
      checks++;
      if (x !== ex || plot !== ep) begin
        errors++;
        $display("FAIL clip_px%0d got=(%0d,p%b) want=(%0d,p%b)", i, x, plot, ex, ep);
      end
    end
    @(negedge clk);
    checks++;
    if (p_ack !== 1'b1 || nplot != 4) begin
      errors++;
      $display("FAIL clip_done got=ack%b n%0d want=ack1 n4", p_ack, nplot);
    end
    p_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    int bad = 0;
    clr_req = 1'b1;
    for (int p = 0; p < 19200; p++) begin
      @(negedge clk);
      checks++;
      if (x !== 8'(p % 160) || y !== 7'(p / 160) || plot !== 1'b1 || colour !== 3'b000 || busy !== 1'b1) begin
        errors++;
        if (bad < 5) $display("FAIL clear_px%0d got=(%0d,%0d,c%0d,p%b) want=(%0d,%0d,c0,p1)", p, x, y, colour, plot, p % 160, p / 160);
        bad++;
      end
    end
    @(negedge clk);
    checks++;
    if ({clr_ack, p_ack, c_ack, plot, busy} !== 5'b10001) begin
      errors++;
      $display("FAIL clear_done got=%b want=10001", {clr_ack, p_ack, c_ack, plot, busy});
    end
    clr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || clr_ack !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle got=b%b a%b want=b0 a0", busy, clr_ack);
    end
  endtask

  task automatic test_arb();
    logic exp_p [3];
    int   k;
    bit   found;
`ifdef PLOT_ARB_RR_EN
    exp_p = '{1'b1, 1'b0, 1'b1};
`else
    exp_p = '{1'b1, 1'b1, 1'b1};
`endif
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    p_x = 8'd30; p_y = 7'd40; p_colour = 3'b011;
    c_x = 8'd50; c_y = 7'd60; c_colour = 3'b010;
    p_req = 1'b1; c_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      found = 1'b0;
      k = 0;
      while (!found && k < 40) begin
        @(negedge clk);
        k++;
        if (p_ack === 1'b1 || c_ack === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || p_ack !== exp_p[g] || c_ack !== !exp_p[g]) begin
        errors++;
        $display("FAIL arb_grant%0d got=p%b c%b found%b want=p%b c%b", g, p_ack, c_ack, found, exp_p[g], !exp_p[g]);
      end
      checks++;
      if (k != ((g == 0) ? 17 : 18)) begin
        errors++;
        $display("FAIL arb_spacing%0d got=%0d want=%0d", g, k, (g == 0) ? 17 : 18);
      end
    end
    p_req = 1'b0; c_req = 1'b0;
    @(negedge clk);
    c_req = 1'b1;
    @(negedge clk);
    checks++;
    if (x !== 8'd50 || y !== 7'd60 || colour !== 3'b010 || plot !== 1'b1) begin
      errors++;
      $display("FAIL cpu_first got=(%0d,%0d,c%0d,p%b) want=(50,60,c2,p1)", x, y, colour, plot);
    end
    repeat (16) @(negedge clk);
    checks++;
    if (c_ack !== 1'b1 || p_ack !== 1'b0) begin
      errors++;
      $display("FAIL cpu_ack got=c%b p%b want=c1 p0", c_ack, p_ack);
    end
    c_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_preempt_reset();
    p_x = 8'd0; p_y = 7'd0; p_colour = 3'b111; p_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 4) clr_req = 1'b1;
      checks++;
      if (x !== 8'(i % 4) || y !== 7'(i / 4) || colour !== 3'b111 || plot !== 1'b1) begin
        errors++;
        $display("FAIL preempt_px%0d got=(%0d,%0d,c%0d,p%b) want=(%0d,%0d,c7,p1)", i, x, y, colour, plot, i % 4, i / 4);
      end
    end
    @(negedge clk);
    checks++;
    if (p_ack !== 1'b1 || clr_ack !== 1'b0) begin
      errors++;
      $display("FAIL preempt_ack got=p%b clr%b want=p1 clr0", p_ack, clr_ack);
    end
    p_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL preempt_idle got=%b want=0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || plot !== 1'b1 || x !== 8'd0 || y !== 7'd0 || colour !== 3'b000) begin
      errors++;
      $display("FAIL clear_start got=b%b p%b (%0d,%0d,c%0d) want=b1 p1 (0,0,c0)", busy, plot, x, y, colour);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (x !== 8'd50 || y !== 7'd0) begin
      errors++;
      $display("FAIL clear_mid got=(%0d,%0d) want=(50,0)", x, y);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || x !== 8'd0 || clr_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_async got=p%b b%b x%0d a%b want=p0 b0 x0 a0", plot, busy, x, clr_ack);
    end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || plot !== 1'b1 || x !== 8'd0 || clr_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_reeval got=b%b p%b x%0d a%b want=b1 p1 x0 a0", busy, plot, x, clr_ack);
    end
    resetn = 1'b1;
    clr_req = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || clr_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_final got=b%b a%b want=b0 a0", busy, clr_ack);
    end
  endtask

  initial begin
    test_reset();
    test_player_draw();
    test_clip();
    test_clear();
    test_arb();
    test_preempt_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
